// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble serial adder.
package nsa_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } nsa_state_t;
endpackage

// File: rtl/nibble_serial_adder_if.sv
// Nibble-in / result-out handshake bundle; op_sub exists only when NSA_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int MAX_NIBBLES = 4
);
  import nsa_pkg::*;
  localparam int RES_W = NIBBLE_W * MAX_NIBBLES;
  localparam int CNT_W = $clog2(MAX_NIBBLES + 1);

  logic                in_valid;
  logic                in_ready;
  logic [NIBBLE_W-1:0] in_a;
  logic [NIBBLE_W-1:0] in_b;
  logic                in_last;
`ifdef NSA_SUB_EN
  logic                op_sub;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [RES_W-1:0]    out_sum;
  logic                out_carry;
  logic [CNT_W-1:0]    out_count;
  logic                out_trunc;

  modport master (
`ifdef NSA_SUB_EN
    output op_sub,
`endif
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count, out_trunc
  );

  modport slave (
`ifdef NSA_SUB_EN
    input  op_sub,
`endif
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count, out_trunc
  );
endinterface

// File: rtl/nibble_serial_adder_fa.sv
// 4-bit ripple-carry adder; the only arithmetic element of the serial adder.
module full_adder
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                car_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                car_out
);
  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = car_in;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign car_out = w_c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Serial multi-nibble adder: sequences nibbles through full_adder, chains carry, buffers result.
// Optional subtract (op_sub, B inverted, carry-in 1) enabled by defining NSA_SUB_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int MAX_NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int RES_W = NIBBLE_W * MAX_NIBBLES;
  localparam int CNT_W = $clog2(MAX_NIBBLES + 1);

  nsa_state_t          r_state, w_next;
  logic [CNT_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_trunc;
  logic [RES_W-1:0]    r_sum;

  logic                w_first, w_at_max, w_accept, w_close, w_release;
  logic                w_sub, w_cin, w_cout;
  logic [NIBBLE_W-1:0] w_b, w_s;

  assign w_first   = (r_idx == '0);
  assign w_at_max  = (r_idx == CNT_W'(MAX_NIBBLES - 1));
  assign w_accept  = bus.in_valid && (r_state == ACC);
  assign w_close   = w_accept && (bus.in_last || w_at_max);
  assign w_release = (r_state == DONE) && bus.out_ready;

`ifdef NSA_SUB_EN
  logic r_sub;
  // op_sub is taken live on the first nibble, then held for the rest of the op
  assign w_sub = w_first ? bus.op_sub : r_sub;
  assign w_b   = w_sub ? ~bus.in_b : bus.in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_sub <= 1'b0;
    else if (w_accept && w_first) r_sub <= bus.op_sub;
  end
`else
  assign w_sub = 1'b0;
  assign w_b   = bus.in_b;
`endif

  assign w_cin = w_first ? w_sub : r_carry;

  full_adder u_fa (
    .a       (bus.in_a),
    .b       (w_b),
    .car_in  (w_cin),
    .sum     (w_s),
    .car_out (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ACC: begin
        bus.in_ready = 1'b1;
        if (w_close) w_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = ACC;
      end
      default: w_next = ACC;
    endcase
  end

  // idx doubles as the result nibble count once the op has closed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_trunc <= 1'b0;
      r_sum   <= '0;
    end else if (w_release) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_trunc <= 1'b0;
      r_sum   <= '0;
    end else if (w_accept) begin
      for (int n = 0; n < MAX_NIBBLES; n++)
        if (r_idx == CNT_W'(n)) r_sum[n*NIBBLE_W +: NIBBLE_W] <= w_s;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_at_max && !bus.in_last) r_trunc <= 1'b1;
    end
  end

  assign bus.out_sum   = r_sum;
  assign bus.out_carry = r_carry;
  assign bus.out_count = r_idx;
  assign bus.out_trunc = r_trunc;
endmodule
